// File: rtl/sevenseg_pkg.sv
// Shared constants and the hex-to-segment lookup for the seven-segment driver.
package sevenseg_pkg;

  // All segments off (active-low), including the decimal point.
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // gfedcba patterns, active-low. Entry 0 sits in the least significant slot.
  localparam logic [15:0][6:0] SEG7_TAB = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] hex_to_seg7(input logic [3:0] nib);
    return SEG7_TAB[nib];
  endfunction

endpackage

// File: rtl/sevenseg_digit_decode.sv
// Turns the currently scanned nibble/dp into the active-low segment bus.
module sevenseg_digit_decode
  import sevenseg_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       dp_i,
  input  logic       visible_i,
  output logic [7:0] seg_o
);

  // Dark digits drive every segment off so no stray pattern leaks out.
  always_comb begin
    seg_o = visible_i ? {~dp_i, hex_to_seg7(nibble_i)} : SEG_BLANK;
  end

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed N-digit seven-segment scanner with dead time, PWM
// brightness, leading-zero blanking and frame-aligned (tear-free) loads.
module sevenseg_scan_driver
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int SLOT_CYC      = 50000,
  parameter int DEAD_CYC      = 64,
  parameter int BLANK_LEADING = 1,
  parameter int AN_ACTIVE_LOW = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [4*NUM_DIGITS-1:0] data_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic [NUM_DIGITS-1:0]   en_i,
  input  logic                    load_i,
  input  logic [3:0]              bright_i,
  output logic [7:0]              seg_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic                    frame_done_o
);

  localparam int CW  = $clog2(SLOT_CYC);
  localparam int IW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int ACT = SLOT_CYC - DEAD_CYC;
  localparam logic [NUM_DIGITS-1:0] AN_OFF =
    (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [CW-1:0]                 slot_cnt_q;
  logic [IW-1:0]                 idx_q;
  logic [3:0]                    bright_q;
  logic [NUM_DIGITS-1:0][3:0]    pend_data_q, disp_data_q;
  logic [NUM_DIGITS-1:0]         pend_dp_q, pend_en_q, disp_dp_q, disp_en_q;
  logic [7:0]                    seg_q, seg_d;
  logic [NUM_DIGITS-1:0]         an_q, an_d;
  logic                          fd_q;

  logic                          slot_end, frame_end, in_win, visible, run;
  logic [3:0]                    bright_eff;
  logic [31:0]                   on_len;
  logic [NUM_DIGITS-1:0]         blank;
  logic [NUM_DIGITS-1:0]         an_act;

  assign slot_end  = (slot_cnt_q == CW'(SLOT_CYC - 1));
  assign frame_end = slot_end && (idx_q == IW'(NUM_DIGITS - 1));

  // Brightness is taken live on the first slot cycle, then held for the slot.
  assign bright_eff = (slot_cnt_q == '0) ? bright_i : bright_q;
  assign on_len     = ((32'(bright_eff) + 32'd1) * 32'(ACT)) >> 4;
  assign in_win     = (32'(slot_cnt_q) >= 32'(DEAD_CYC)) &&
                      (32'(slot_cnt_q) <  32'(DEAD_CYC) + on_len);

  // Leading-zero mask: walk down from the top digit; disabled digits are
  // transparent, any nonzero nibble or lit dp ends the blank run.
  always_comb begin
    blank = '0;
    run   = 1'b1;
    for (int d = NUM_DIGITS - 1; d >= 1; d--) begin
      run      = run & (~disp_en_q[d] | ((disp_data_q[d] == 4'h0) & ~disp_dp_q[d]));
      blank[d] = run & (BLANK_LEADING != 0);
    end
  end

  assign visible = in_win && disp_en_q[idx_q] && !blank[idx_q];

  sevenseg_digit_decode u_dec (
    .nibble_i  (disp_data_q[idx_q]),
    .dp_i      (disp_dp_q[idx_q]),
    .visible_i (visible),
    .seg_o     (seg_d)
  );

  // Only the scanned digit can ever be selected, so AN is one-hot or idle.
  always_comb begin
    an_act = visible ? (NUM_DIGITS'(1) << idx_q) : '0;
    an_d   = (AN_ACTIVE_LOW != 0) ? ~an_act : an_act;
  end

  // Slot counter, digit index and per-slot brightness sample.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      slot_cnt_q <= '0;
      idx_q      <= '0;
      bright_q   <= '0;
    end else begin
      if (slot_cnt_q == '0) bright_q <= bright_i;
      if (slot_end) begin
        slot_cnt_q <= '0;
        idx_q      <= (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end else begin
        slot_cnt_q <= slot_cnt_q + 1'b1;
      end
    end
  end

  // Loads land in pending; display only changes at the frame boundary, with
  // a same-cycle load bypassing straight to display.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pend_data_q <= '0;
      pend_dp_q   <= '0;
      pend_en_q   <= '0;
      disp_data_q <= '0;
      disp_dp_q   <= '0;
      disp_en_q   <= '0;
    end else begin
      if (load_i) begin
        pend_data_q <= data_i;
        pend_dp_q   <= dp_i;
        pend_en_q   <= en_i;
      end
      if (frame_end) begin
        disp_data_q <= load_i ? data_i : pend_data_q;
        disp_dp_q   <= load_i ? dp_i   : pend_dp_q;
        disp_en_q   <= load_i ? en_i   : pend_en_q;
      end
    end
  end

  // Output registers: one cycle behind the slot counter.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      seg_q <= SEG_BLANK;
      an_q  <= AN_OFF;
      fd_q  <= 1'b0;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
      fd_q  <= frame_end;
    end
  end

  assign seg_o        = seg_q;
  assign an_o         = an_q;
  assign frame_done_o = fd_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Self-checking bench: directed scenarios plus random loads, every cycle
// compared against a frame/slot arithmetic model of the display.
module tb_sevenseg_scan_driver;

  localparam int N    = 4;
  localparam int SLOT = 36;
  localparam int DEAD = 4;
  localparam int FR   = N * SLOT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  dp = '0, en = '0, bright = 4'd15;
  logic        load = 1'b0;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        fd;

  always #5 clk = ~clk;

  sevenseg_scan_driver #(
    .NUM_DIGITS(N), .SLOT_CYC(SLOT), .DEAD_CYC(DEAD),
    .BLANK_LEADING(1), .AN_ACTIVE_LOW(1)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .data_i(data), .dp_i(dp), .en_i(en),
    .load_i(load), .bright_i(bright), .seg_o(seg), .an_o(an),
    .frame_done_o(fd)
  );

  int vecs = 0;
  int errs = 0;
  int k;                        // clock edges since reset release
  logic [15:0] m_pd, m_dd;      // pending / displayed data
  logic [3:0]  m_pp, m_pe, m_dp, m_de;
  int          m_br;
  logic [7:0]  segtab [16] = '{8'h40, 8'h79, 8'h24, 8'h30, 8'h19, 8'h12, 8'h02, 8'h78,
                               8'h00, 8'h10, 8'h08, 8'h03, 8'h46, 8'h21, 8'h06, 8'h0E};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h at edge %0d", tag, got, exp, k);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_seg"}, seg, 8'hFF);
    check({tag, "_an"},  an,  4'hF);
    check({tag, "_fd"},  fd,  1'b0);
  endtask

  task automatic model_reset();
    k = 0;
    m_pd = '0; m_pp = '0; m_pe = '0;
    m_dd = '0; m_dp = '0; m_de = '0;
    m_br = 0;
  endtask

  // One clock: predict what the edge produces, clock it, compare.
  task automatic tick();
    int cnt, idx, onlen;
    bit vis, blank, efd;
    logic [7:0] eseg, ent;
    logic [3:0] ean;
    cnt = k % SLOT;
    idx = (k / SLOT) % N;
    if (cnt == 0) m_br = int'(bright);
    onlen = ((m_br + 1) * (SLOT - DEAD)) / 16;
    blank = (idx != 0);
    for (int j = N - 1; j >= idx; j--)
      if (m_de[j] && (m_dd[j*4 +: 4] != 4'h0 || m_dp[j])) blank = 0;
    vis  = (cnt >= DEAD) && (cnt < DEAD + onlen) && m_de[idx] && !blank;
    ent  = segtab[m_dd[idx*4 +: 4]];
    eseg = vis ? {~m_dp[idx], ent[6:0]} : 8'hFF;
    ean  = vis ? ~(4'b0001 << idx) : 4'hF;
    efd  = (k % FR == FR - 1);
    if (k % FR == FR - 1) begin
      if (load) begin m_dd = data; m_dp = dp; m_de = en; end
      else      begin m_dd = m_pd; m_dp = m_pp; m_de = m_pe; end
    end
    if (load) begin m_pd = data; m_pp = dp; m_pe = en; end
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    k++;
    check("seg", seg, eseg);
    check("an", an, ean);
    check("frame_done", fd, efd);
    check("an_onehot", ($countones(~an) <= 1), 1'b1);
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] e);
    data = d; dp = p; en = e; load = 1'b1;
    tick();
  endtask

  initial begin
    // Reset hold and idle frames with nothing loaded.
    model_reset();
    repeat (3) @(negedge clk);
    check_reset("rst_hold");
    rst_n = 1'b1;
    repeat (2 * FR) tick();

    // Basic scan at full brightness.
    bright = 4'd15;
    do_load(16'h12AF, 4'h0, 4'hF);
    repeat (2 * FR) tick();

    // Leading zeros, then a dp on the top digit stops the blanking.
    do_load(16'h0050, 4'h0, 4'hF);
    repeat (2 * FR) tick();
    do_load(16'h0050, 4'h8, 4'hF);
    repeat (2 * FR) tick();

    // Brightness extremes and mid-range.
    bright = 4'd0;
    repeat (2 * FR) tick();
    bright = 4'd7;
    repeat (2 * FR) tick();
    bright = 4'd15;

    // Tear-free loads: second load mid-frame waits for the boundary.
    while (k % FR != 10) tick();
    do_load(16'h1111, 4'h0, 4'hF);
    repeat (40) tick();
    do_load(16'h2222, 4'h0, 4'hF);
    repeat (2 * FR) tick();

    // Load exactly on the boundary cycle bypasses to display.
    while (k % FR != FR - 1) tick();
    do_load(16'h3C5E, 4'h2, 4'hF);
    repeat (FR) tick();

    // Async reset while digit 2 is lit.
    while (!(((k / SLOT) % N) == 2 && (k % SLOT) == 10)) tick();
    check("pre_rst_an", an, 4'b1011);
    rst_n = 1'b0;
    #1;
    check_reset("rst_mid");
    @(negedge clk);
    check_reset("rst_mid_hold");
    model_reset();
    rst_n = 1'b1;
    repeat (FR) tick();

    // Random loads, enables, dps and brightness at random spacing.
    repeat (14) begin
      bright = 4'($urandom);
      do_load(16'($urandom), 4'($urandom), 4'($urandom));
      repeat ($urandom_range(20, 220)) tick();
    end
    repeat (FR) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
